// File: rtl/eth_speed_pkg.sv
// eth_speed_pkg: shared types and constants for the RGMII link-speed detector.
//
// Contents
//   speed_t          2-bit link speed code (00=10M, 01=100M, 10=1000M)
//   SPEED_RST        speed presented out of reset
//   sanitize_speed() maps a raw 2-bit code onto a legal speed_t
package eth_speed_pkg;

    typedef enum logic [1:0] {
        SPEED_10M   = 2'b00,
        SPEED_100M  = 2'b01,
        SPEED_1000M = 2'b10
    } speed_t;

    localparam speed_t SPEED_RST = SPEED_1000M;

    // Code 2'b11 has no meaning on the MAC side; fold it onto gigabit.
    function automatic speed_t sanitize_speed(input logic [1:0] code);
        if (code == 2'b11) begin
            return SPEED_1000M;
        end
        return speed_t'(code);
    endfunction

endpackage

// File: rtl/eth_sync_edge.sv
// eth_sync_edge: multi-flop synchroniser for an asynchronous toggle plus an
// edge detector on the synchronised level.
//
// Ports
//   clk       in   destination clock
//   rst_n     in   asynchronous active-low reset
//   async_in  in   toggle from a foreign clock domain
//   edge_o    out  high for one clk cycle after each toggle of async_in
//
// A toggle is counted by the consumer SYNC_STAGES+1 cycles after it is
// launched: SYNC_STAGES cycles through the chain, then the edge cycle.
module eth_sync_edge #(
    parameter int unsigned SYNC_STAGES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Either polarity of the toggle is an edge.
    assign edge_o = sync_q[SYNC_STAGES-1] ^ last_q;

endmodule

// File: rtl/eth_speed_detect.sv
// eth_speed_detect: classifies the RGMII receive clock as 10M, 100M or 1000M
// by counting synchronised prescaler toggles against the local reference clock.
//
// Ports
//   clk              in   reference clock (gtx_clk domain)
//   rst_n            in   asynchronous active-low reset
//   en               in   measurement enable; low clears counters, holds speed
//   rx_prescale_tgl  in   asynchronous toggle from the rx domain
//   cfg_force_en     in   software override of speed
//   cfg_force_speed  in   forced speed code (11 treated as 10)
//   speed            out  filtered link speed, reset 1000M
//   mii_select       out  high for 10M/100M (MII mode), reset 0
//   speed_chg        out  one-cycle pulse when speed changes
//   meas_valid       out  one-cycle pulse at every window end
//   meas_speed       out  raw candidate from the last window, reset 1000M
//   link_down        out  set after LOSS_WINDOWS consecutive edge-free windows
//
// A window closes either when the edge counter fills (fast clock: compare the
// elapsed reference count with THRESH_100M) or when the reference counter
// fills first (slow or absent clock: 10M). The cycle after a window end (StEnd)
// applies the hysteresis decision, so speed moves one cycle after meas_valid.
module eth_speed_detect
    import eth_speed_pkg::*;
#(
    parameter int unsigned REF_CNT_W    = 7,
    parameter int unsigned EDGE_CNT_W   = 2,
    parameter int unsigned THRESH_100M  = 32,
    parameter int unsigned STABLE_CNT   = 2,
    parameter int unsigned SYNC_STAGES  = 3,
    parameter int unsigned LOSS_WINDOWS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       rx_prescale_tgl,
    input  logic       cfg_force_en,
    input  logic [1:0] cfg_force_speed,
    output logic [1:0] speed,
    output logic       mii_select,
    output logic       speed_chg,
    output logic       meas_valid,
    output logic [1:0] meas_speed,
    output logic       link_down
);

    localparam logic [REF_CNT_W-1:0] THRESH_REF = REF_CNT_W'(THRESH_100M);
    localparam logic [3:0]           STABLE_M   = 4'(STABLE_CNT);
    localparam logic [7:0]           LOSS_M     = 8'(LOSS_WINDOWS);

    typedef enum logic {
        StCount,
        StEnd
    } win_state_t;

    logic                  rx_edge;
    win_state_t            state_q;
    logic [REF_CNT_W-1:0]  ref_cnt_q;
    logic [EDGE_CNT_W-1:0] edge_cnt_q;
    logic [3:0]            match_cnt_q;
    logic [7:0]            idle_cnt_q;
    speed_t                speed_q;
    speed_t                meas_speed_q;
    logic                  mii_select_q;
    logic                  speed_chg_q;
    logic                  meas_valid_q;
    logic                  link_down_q;

    logic       edge_end;
    logic       ovf_end;
    logic       win_end;
    speed_t     cand;
    speed_t     force_spd;
    logic [3:0] match_next;
    logic [7:0] idle_next;
    logic       hyst_take;

    eth_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (rx_prescale_tgl),
        .edge_o   (rx_edge)
    );

    always_comb begin
        edge_end  = &edge_cnt_q;
        ovf_end   = &ref_cnt_q;
        // Edge termination takes priority when both counters fill together.
        win_end   = en && (edge_end || ovf_end);
        force_spd = sanitize_speed(cfg_force_speed);

        if (edge_end) begin
            cand = (ref_cnt_q >= THRESH_REF) ? SPEED_100M : SPEED_1000M;
        end else begin
            cand = SPEED_10M;
        end

        if (cand == meas_speed_q) begin
            match_next = (match_cnt_q >= STABLE_M) ? STABLE_M : match_cnt_q + 4'd1;
        end else begin
            match_next = 4'd1;
        end

        idle_next = (idle_cnt_q >= LOSS_M) ? LOSS_M : idle_cnt_q + 8'd1;

        hyst_take = en && (state_q == StEnd) && (match_cnt_q == STABLE_M)
                    && (meas_speed_q != speed_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StCount;
            ref_cnt_q    <= '0;
            edge_cnt_q   <= '0;
            match_cnt_q  <= '0;
            idle_cnt_q   <= '0;
            speed_q      <= SPEED_RST;
            meas_speed_q <= SPEED_RST;
            mii_select_q <= 1'b0;
            speed_chg_q  <= 1'b0;
            meas_valid_q <= 1'b0;
            link_down_q  <= 1'b0;
        end else begin
            speed_chg_q  <= 1'b0;
            meas_valid_q <= 1'b0;

            // Speed update: software override first, then the hysteresis
            // decision taken in the cycle after a window end.
            if (cfg_force_en) begin
                speed_q      <= force_spd;
                mii_select_q <= (force_spd != SPEED_1000M);
                speed_chg_q  <= (force_spd != speed_q);
            end else if (hyst_take) begin
                speed_q      <= meas_speed_q;
                mii_select_q <= (meas_speed_q != SPEED_1000M);
                speed_chg_q  <= 1'b1;
            end

            if (!en) begin
                state_q     <= StCount;
                ref_cnt_q   <= '0;
                edge_cnt_q  <= '0;
                match_cnt_q <= '0;
                idle_cnt_q  <= '0;
            end else if (win_end) begin
                state_q      <= StEnd;
                // An edge arriving in the closing cycle is dropped on purpose.
                ref_cnt_q    <= '0;
                edge_cnt_q   <= '0;
                meas_speed_q <= cand;
                meas_valid_q <= 1'b1;
                match_cnt_q  <= match_next;
                if (edge_cnt_q != '0) begin
                    idle_cnt_q  <= '0;
                    link_down_q <= 1'b0;
                end else begin
                    // Zero edges implies the window closed by overflow.
                    idle_cnt_q <= idle_next;
                    if (idle_next == LOSS_M) begin
                        link_down_q <= 1'b1;
                    end
                end
            end else begin
                state_q    <= StCount;
                ref_cnt_q  <= ref_cnt_q + REF_CNT_W'(1);
                edge_cnt_q <= edge_cnt_q + EDGE_CNT_W'(rx_edge);
            end
        end
    end

    assign speed      = speed_q;
    assign mii_select = mii_select_q;
    assign speed_chg  = speed_chg_q;
    assign meas_valid = meas_valid_q;
    assign meas_speed = meas_speed_q;
    assign link_down  = link_down_q;

endmodule

// File: tb/tb_eth_speed_detect.sv
// Self-checking bench for eth_speed_detect: randomised toggle rates compared
// cycle by cycle against a window-level reference model, plus scenario checks.
module tb_eth_speed_detect;

    localparam int REF_MAX   = 127;  // 2^7-1
    localparam int EDGE_MAX  = 3;    // 2^2-1
    localparam int THRESH    = 32;
    localparam int STABLE    = 2;
    localparam int SYNC      = 3;
    localparam int LOSS      = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       rx_prescale_tgl;
    logic       cfg_force_en;
    logic [1:0] cfg_force_speed;
    logic [1:0] speed;
    logic       mii_select;
    logic       speed_chg;
    logic       meas_valid;
    logic [1:0] meas_speed;
    logic       link_down;

    always #4 clk = ~clk;

    eth_speed_detect #(
        .REF_CNT_W    (7),
        .EDGE_CNT_W   (2),
        .THRESH_100M  (THRESH),
        .STABLE_CNT   (STABLE),
        .SYNC_STAGES  (SYNC),
        .LOSS_WINDOWS (LOSS)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en              (en),
        .rx_prescale_tgl (rx_prescale_tgl),
        .cfg_force_en    (cfg_force_en),
        .cfg_force_speed (cfg_force_speed),
        .speed           (speed),
        .mii_select      (mii_select),
        .speed_chg       (speed_chg),
        .meas_valid      (meas_valid),
        .meas_speed      (meas_speed),
        .link_down       (link_down)
    );

    int checks;
    int failures;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: window rules applied with plain integers.
    int m_ref, m_edges, m_match, m_idle;
    int m_speed, m_meas, m_ld, m_mv, m_chg;
    bit m_pending;
    int cyc;
    int deliver[$];  // clock index at which each toggle is counted

    // Stimulus state
    int rate_lo, rate_hi, countdown;
    bit alt_mode, alt_fast;
    int n_chg, n_mv;

    task automatic model_reset();
        m_ref = 0; m_edges = 0; m_match = 0; m_idle = 0;
        m_speed = 2; m_meas = 2; m_ld = 0; m_mv = 0; m_chg = 0;
        m_pending = 0;
        deliver.delete();
    endtask

    task automatic model_step(input bit e_en, input bit f_en, input int f_spd, input bit e_in);
        int cand, fs;
        m_mv = 0;
        m_chg = 0;
        if (f_en) begin
            fs = (f_spd == 3) ? 2 : f_spd;
            m_chg = (fs != m_speed);
            m_speed = fs;
        end else if (e_en && m_pending && m_match == STABLE && m_meas != m_speed) begin
            m_speed = m_meas;
            m_chg = 1;
        end
        m_pending = 0;
        if (!e_en) begin
            m_ref = 0; m_edges = 0; m_match = 0; m_idle = 0;
        end else if (m_edges == EDGE_MAX || m_ref == REF_MAX) begin
            if (m_edges == EDGE_MAX) cand = (m_ref >= THRESH) ? 1 : 2;
            else cand = 0;
            m_match = (cand == m_meas) ? ((m_match + 1 > STABLE) ? STABLE : m_match + 1) : 1;
            m_meas = cand;
            m_mv = 1;
            m_pending = 1;
            if (m_edges >= 1) begin
                m_idle = 0;
                m_ld = 0;
            end else begin
                m_idle = (m_idle + 1 > LOSS) ? LOSS : m_idle + 1;
                if (m_idle == LOSS) m_ld = 1;
            end
            m_ref = 0;
            m_edges = 0;
        end else begin
            m_ref++;
            if (e_in) m_edges++;
        end
    endtask

    function automatic int pick();
        return $urandom_range(rate_hi, rate_lo);
    endfunction

    task automatic set_rate(input int lo, input int hi);
        rate_lo = lo;
        rate_hi = hi;
        countdown = (lo > 0) ? pick() : 0;
    endtask

    task automatic tick();
        bit e_in;
        int np;
        e_in = 0;
        if (deliver.size() > 0 && deliver[0] == cyc + 1) begin
            e_in = 1;
            void'(deliver.pop_front());
        end
        model_step(en, cfg_force_en, int'(cfg_force_speed), e_in);
        @(posedge clk);
        cyc++;
        #1;
        check_val("speed", speed, m_speed);
        check_val("mii_select", mii_select, (m_speed != 2));
        check_val("speed_chg", speed_chg, m_chg);
        check_val("meas_valid", meas_valid, m_mv);
        check_val("meas_speed", meas_speed, m_meas);
        check_val("link_down", link_down, m_ld);
        if (speed_chg === 1'b1) n_chg++;
        if (meas_valid === 1'b1) n_mv++;
        if (alt_mode && m_mv == 1) begin
            alt_fast = !alt_fast;
            if (alt_fast) begin rate_lo = 4; rate_hi = 4; end
            else begin rate_lo = 20; rate_hi = 20; end
            np = pick();
            if (np < countdown) countdown = np;
        end
        if (rate_lo > 0) begin
            countdown--;
            if (countdown <= 0) begin
                rx_prescale_tgl = ~rx_prescale_tgl;
                deliver.push_back(cyc + SYNC + 1);
                countdown = pick();
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Called just after a posedge; checks that reset acts without a clock.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_val("rst_speed", speed, 2);
        check_val("rst_mii", mii_select, 0);
        check_val("rst_chg", speed_chg, 0);
        check_val("rst_mv", meas_valid, 0);
        check_val("rst_meas", meas_speed, 2);
        check_val("rst_link", link_down, 0);
        rx_prescale_tgl = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        rst_n = 1'b1;
        model_reset();
        countdown = (rate_lo > 0) ? pick() : 0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        n_chg = 0;
        n_mv = 0;
        alt_mode = 0;
        alt_fast = 0;
        rate_lo = 0;
        rate_hi = 0;
        countdown = 0;
        rst_n = 1'b1;
        en = 1'b1;
        rx_prescale_tgl = 1'b0;
        cfg_force_en = 1'b0;
        cfg_force_speed = 2'b00;
        #1;
        rst_n = 1'b0;
        #1;
        check_val("init_speed", speed, 2);
        check_val("init_mii", mii_select, 0);
        check_val("init_meas", meas_speed, 2);
        check_val("init_link", link_down, 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1000M: speed stays gigabit, no change pulses.
        set_rate(3, 5);
        n_chg = 0;
        run(200);
        check_val("g_speed", speed, 2);
        check_val("g_mii", mii_select, 0);
        check_val("g_chg_cnt", n_chg, 0);

        // 1000M -> 100M: exactly one change.
        set_rate(18, 22);
        n_chg = 0;
        run(400);
        check_val("f_speed", speed, 1);
        check_val("f_mii", mii_select, 1);
        check_val("f_chg_cnt", n_chg, 1);

        // Rates straddling the 100M threshold and the overflow/edge tie.
        set_rate(9, 12);
        run(600);
        set_rate(40, 44);
        run(800);

        // 10M: overflow windows, link stays up.
        set_rate(190, 210);
        run(1000);
        check_val("t_speed", speed, 0);
        check_val("t_link", link_down, 0);
        check_val("t_mii", mii_select, 1);

        // Loss of rx clock, then recovery.
        set_rate(0, 0);
        run(700);
        check_val("loss_link", link_down, 1);
        set_rate(190, 210);
        run(500);
        check_val("recov_link", link_down, 0);

        // Alternating rates window by window.
        set_rate(4, 4);
        run(200);
        alt_mode = 1;
        alt_fast = 1;
        run(1500);
        alt_mode = 0;

        // Force override while at 1000M.
        set_rate(4, 4);
        run(300);
        check_val("pf_speed", speed, 2);
        cfg_force_en = 1'b1;
        cfg_force_speed = 2'b11;
        tick();
        check_val("force11_speed", speed, 2);
        cfg_force_speed = 2'b01;
        n_chg = 0;
        tick();
        check_val("force_speed", speed, 1);
        check_val("force_chg", speed_chg, 1);
        run(200);
        check_val("force_hold", speed, 1);
        check_val("force_chg_cnt", n_chg, 1);
        cfg_force_en = 1'b0;
        run(300);
        check_val("release_speed", speed, 2);

        // Asynchronous reset mid-window at 100M.
        set_rate(18, 22);
        run(150);
        do_reset();
        run(300);
        check_val("post_rst_speed", speed, 1);

        // Measurement disabled: no windows, speed holds.
        en = 1'b0;
        n_mv = 0;
        run(300);
        check_val("dis_mv_cnt", n_mv, 0);
        check_val("dis_speed", speed, 1);
        en = 1'b1;
        set_rate(3, 5);
        run(400);
        check_val("reen_speed", speed, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/eth_speed_detect.md
# eth_speed_detect

Parametrised RGMII link-speed detector. It classifies the PHY receive clock as 10M, 100M or 1000M by counting edges of a prescaled rx-clock toggle against the local transmit reference clock. Compared with the fixed detector in the 1G RGMII MAC wrapper, it adds measurement-width parameters, hysteresis over consecutive windows, link-loss detection, a software force override and status strobes. It sits between the RGMII PHY interface and the MAC, and drives the `speed`/`mii_select` inputs of both.

## Interface
- REF_CNT_W, 7: reference window counter width; window length is 2^REF_CNT_W−1 clk cycles.
- EDGE_CNT_W, 2: edge counter width; a window ends after 2^EDGE_CNT_W−1 edges.
- THRESH_100M, 32: if ref_cnt ≥ THRESH_100M at an edge-terminated window, the candidate is 100M; otherwise it is 1000M. Must be < 2^REF_CNT_W−1.
- STABLE_CNT, 2: number of consecutive identical candidates required to change `speed`, 1..15.
- SYNC_STAGES, 3: synchroniser depth for `rx_prescale_tgl`, ≥2.
- LOSS_WINDOWS, 4: number of consecutive zero-edge windows that asserts `link_down`, 1..255.
- clk  in  1  reference clock (gtx_clk domain).
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  measurement enable; low clears counters and freezes outputs.
- rx_prescale_tgl  in  1  asynchronous toggle from the rx domain (rx prescaler bit 2, period 8 rx_clk).
- cfg_force_en  in  1  force `speed` to cfg_force_speed.
- cfg_force_speed  in  2  forced speed code.
- speed  out  2  00=10M, 01=100M, 10=1000M; reset 2'b10.
- mii_select  out  1  registered; high when speed≠10; reset 0.
- speed_chg  out  1  one-cycle pulse when `speed` changes; reset 0.
- meas_valid  out  1  one-cycle pulse at every window end; reset 0.
- meas_speed  out  2  candidate from the last window; reset 2'b10.
- link_down  out  1  no rx clock detected; reset 0.

## Operation
- Synchroniser: SYNC_STAGES flops followed by one extra flop. An edge is detected when the last two stages differ. Detect latency is SYNC_STAGES+1 cycles.
- Counting: ref_cnt increments every cycle while en=1. edge_cnt increments on each detected edge.
- A window ends on one of two conditions:
  - (a) Edge termination: registered edge_cnt is all-ones. Candidate = ref_cnt ≥ THRESH_100M ? 01 : 10.
  - (b) Reference overflow: ref_cnt is all-ones. Candidate = 00.
- If (a) and (b) occur in the same cycle, (a) wins.
- At window end: both counters clear, any edge arriving in that cycle is discarded, meas_valid pulses and meas_speed updates.
- Hysteresis: match_cnt saturates at STABLE_CNT.
  - Candidate equal to the previous candidate: match_cnt+1.
  - Candidate different: match_cnt=1.
  - When match_cnt reaches STABLE_CNT and candidate≠speed: speed←candidate and speed_chg pulses.
- Link loss:
  - A window ending by (b) with edge_cnt==0 increments idle_cnt (saturating).
  - When idle_cnt reaches LOSS_WINDOWS, link_down←1.
  - Any window with edge_cnt≥1 clears idle_cnt and link_down.
  - `speed` still follows hysteresis while link_down=1.
- Force: cfg_force_en=1 sets speed←cfg_force_speed on the next cycle, pulsing speed_chg if the value differs. Measurement continues and meas_* stay live. On release, speed holds until the next hysteresis decision.
- cfg_force_speed=11 is illegal; the block treats it as 10.
- en=0: counters, match_cnt and idle_cnt are cleared. speed and link_down hold. The synchroniser keeps running.

## Timing
- All outputs are registered.
- speed_chg, speed and mii_select update in the same cycle, 1 cycle after the deciding window end. meas_valid is coincident with meas_speed update.
- Defaults with 125 MHz clk:
  - 1000M: an edge every 4 clk, so a window is about 12 clk.
  - 100M: an edge every 20 clk, so a window is about 60 clk (≥32).
  - 10M: an edge every 200 clk, so windows end by overflow at 127 clk.
- Asynchronous reset mid-window returns every register to its reset value immediately. The first window starts on the first clk after rst_n deasserts.

## Structure
- Package eth_speed_pkg:
  - speed_t enum: SPEED_10M=2'b00, SPEED_100M=2'b01, SPEED_1000M=2'b10.
  - Constant SPEED_RST=SPEED_1000M.
- Sub-module eth_sync_edge: parametrised synchroniser plus edge detector with output `edge_o`.
- Top level: counters, window FSM (COUNT, END) and hysteresis/link-loss logic.

## Test plan
- 1000M: toggle rx_prescale_tgl every 4 clk for 10 windows -> meas_speed=10 on every meas_valid, speed stays 10, speed_chg never fires, mii_select=0.
- 1000M→100M: switch to a toggle every 20 clk -> speed becomes 01 exactly 1 cycle after the 2nd 01 window, one speed_chg pulse, mii_select=1.
- 10M and loss:
  - Toggle every 200 clk -> speed becomes 00 after 2 overflow windows, link_down stays 0.
  - Stop toggling -> link_down=1 after 4 zero-edge windows (~512 clk).
  - Resume toggling -> link_down clears on the next edge-bearing window.
- Hysteresis: alternate 100M/1000M toggle rates window-by-window -> meas_speed alternates, speed never changes, no speed_chg.
- Force: cfg_force_en=1 with cfg_force_speed=01 while at 1000M -> speed=01 next cycle with one speed_chg pulse; release -> speed returns to 10 after 2 windows.
- Reset/enable:
  - Assert rst_n low mid-window at 100M -> all outputs reset (speed=10) asynchronously.
  - en=0 for 300 clk -> no meas_valid, speed holds.
